// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_ctrl_pkg
// Description : Shared control definitions for the CPU sequencer: phase
//               encoding, branch condition codes and flag bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  // Sequencer phases. The numeric encoding is visible on the state output
  // and is relied on by the decoder for gating, so it must stay fixed.
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } state_t;

  // Branch condition codes. Codes 100..111 are reserved and never true.
  localparam logic [2:0] COND_EQ = 3'b000;  // Z
  localparam logic [2:0] COND_LT = 3'b001;  // S ^ V
  localparam logic [2:0] COND_LE = 3'b010;  // Z | (S ^ V)
  localparam logic [2:0] COND_NE = 3'b011;  // !Z

  // Bit positions inside the {S,Z,C,V} flag vector.
  localparam int unsigned FLAG_S = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned FLAG_W = 4;

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond_eval
// Description : Combinational branch resolution. Decides whether the PC is
//               loaded from the branch/jump target.
// Revision    : 1.0 - initial release
// Ports       : cond_i      - latched condition code
//               flags_i     - registered {S,Z,C,V} flags
//               is_branch_i - latched conditional-branch decode
//               is_jump_i   - latched unconditional-jump decode
//               taken_o     - target should be loaded into the PC
// ============================================================================
module branch_cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [2:0]        cond_i,
  input  logic [FLAG_W-1:0] flags_i,
  input  logic              is_branch_i,
  input  logic              is_jump_i,
  output logic              taken_o
);

  logic flag_s;
  logic flag_z;
  logic flag_v;
  logic cond_true;
  // Carry takes part in no current condition code.
  logic unused_carry;

  assign flag_s       = flags_i[FLAG_S];
  assign flag_z       = flags_i[FLAG_Z];
  assign flag_v       = flags_i[FLAG_V];
  assign unused_carry = flags_i[FLAG_C];

  always_comb begin
    cond_true = 1'b0;
    case (cond_i)
      COND_EQ: cond_true = flag_z;
      COND_LT: cond_true = flag_s ^ flag_v;
      COND_LE: cond_true = flag_z | (flag_s ^ flag_v);
      COND_NE: cond_true = ~flag_z;
      default: cond_true = 1'b0;
    endcase
  end

  // A jump is taken regardless of the branch condition.
  assign taken_o = is_jump_i | (is_branch_i & cond_true);

endmodule : branch_cond_eval
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Multi-cycle instruction sequencer. Steps the core through
//               FETCH/DECODE/EXEC/WB, owns the program counter and the
//               {S,Z,C,V} flag register, resolves branches from the latched
//               flags and stops in HALT until reset.
// Revision    : 1.0 - initial release
// Ports       : clk        - core clock, rising edge
//               rst        - asynchronous reset, active high
//               mem_ready  - instruction memory data valid at pc
//               is_branch, is_jump, is_halt, writes_reg, cond, target
//                          - decode fields, sampled in DECODE only
//               flag_we    - ALU flags valid, honoured in EXEC only
//               flag_in    - ALU flags {S,Z,C,V}
//               pc         - current program counter
//               ir_load    - instruction register load pulse (FETCH)
//               reg_we     - register-file write pulse (WB)
//               flags      - registered flags {S,Z,C,V}
//               state      - current phase encoding
//               taken      - PC loaded from target this WB
//               halted     - core stopped
// ============================================================================
module pc_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned             PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]     RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_ready,
  input  logic                is_branch,
  input  logic                is_jump,
  input  logic                is_halt,
  input  logic                writes_reg,
  input  logic [2:0]          cond,
  input  logic [PC_WIDTH-1:0] target,
  input  logic                flag_we,
  input  logic [FLAG_W-1:0]   flag_in,
  output logic [PC_WIDTH-1:0] pc,
  output logic                ir_load,
  output logic                reg_we,
  output logic [FLAG_W-1:0]   flags,
  output logic [2:0]          state,
  output logic                taken,
  output logic                halted
);

  localparam logic [PC_WIDTH-1:0] PC_INC = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t              state_q,  state_d;
  logic [PC_WIDTH-1:0] pc_q,     pc_d;
  logic [FLAG_W-1:0]   flags_q,  flags_d;
  logic                br_q,     br_d;
  logic                jmp_q,    jmp_d;
  logic                wr_q,     wr_d;
  logic [2:0]          cond_q,   cond_d;
  logic [PC_WIDTH-1:0] target_q, target_d;
  logic                taken_q,  taken_d;
  logic                cond_taken;

  // Branch resolution always sees the flags as they were at the start of
  // EXEC, so an instruction's own flag update never steers its own branch.
  branch_cond_eval u_branch_cond_eval (
    .cond_i      (cond_q),
    .flags_i     (flags_q),
    .is_branch_i (br_q),
    .is_jump_i   (jmp_q),
    .taken_o     (cond_taken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      flags_q  <= '0;
      br_q     <= 1'b0;
      jmp_q    <= 1'b0;
      wr_q     <= 1'b0;
      cond_q   <= 3'b000;
      target_q <= '0;
      taken_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      flags_q  <= flags_d;
      br_q     <= br_d;
      jmp_q    <= jmp_d;
      wr_q     <= wr_d;
      cond_q   <= cond_d;
      target_q <= target_d;
      taken_q  <= taken_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    flags_d  = flags_q;
    br_d     = br_q;
    jmp_d    = jmp_q;
    wr_d     = wr_q;
    cond_d   = cond_q;
    target_d = target_q;
    taken_d  = taken_q;
    ir_load  = 1'b0;
    reg_we   = 1'b0;
    taken    = 1'b0;
    halted   = 1'b0;

    case (state_q)
      FETCH: begin
        // The only output with a direct input dependency: the IR is loaded
        // in the same cycle memory reports valid data.
        ir_load = mem_ready;
        if (mem_ready) begin
          state_d = DECODE;
        end
      end

      DECODE: begin
        br_d     = is_branch;
        jmp_d    = is_jump;
        wr_d     = writes_reg;
        cond_d   = cond;
        target_d = target;
        // HALT wins over every other decode bit.
        state_d  = is_halt ? HALT : EXEC;
      end

      EXEC: begin
        taken_d = cond_taken;
        if (flag_we) begin
          flags_d = flag_in;
        end
        state_d = WB;
      end

      WB: begin
        reg_we  = wr_q;
        taken   = taken_q;
        // Natural wrap from all-ones back to zero.
        pc_d    = taken_q ? target_q : (pc_q + PC_INC);
        state_d = FETCH;
      end

      HALT: begin
        halted  = 1'b1;
        state_d = HALT;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign pc    = pc_q;
  assign flags = flags_q;
  assign state = state_q;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. Each instruction is
//               modelled as a whole: expected PC, flags and taken outcome
//               come from the branch rules applied to a software copy of the
//               flags, and every phase of the instruction is checked.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ready;
  logic        is_branch;
  logic        is_jump;
  logic        is_halt;
  logic        writes_reg;
  logic [2:0]  cond;
  logic [15:0] target;
  logic        flag_we;
  logic [3:0]  flag_in;
  logic [15:0] pc;
  logic        ir_load;
  logic        reg_we;
  logic [3:0]  flags;
  logic [2:0]  state;
  logic        taken;
  logic        halted;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference state of the architectural registers.
  logic [15:0] m_pc;
  logic [3:0]  m_flags;

  pc_sequencer #(
    .PC_WIDTH (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_ready  (mem_ready),
    .is_branch  (is_branch),
    .is_jump    (is_jump),
    .is_halt    (is_halt),
    .writes_reg (writes_reg),
    .cond       (cond),
    .target     (target),
    .flag_we    (flag_we),
    .flag_in    (flag_in),
    .pc         (pc),
    .ir_load    (ir_load),
    .reg_we     (reg_we),
    .flags      (flags),
    .state      (state),
    .taken      (taken),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_cond_true(input logic [2:0] c, input bit s, input bit z, input bit v);
    case (c)
      3'd0:    return z;
      3'd1:    return s ^ v;
      3'd2:    return z | (s ^ v);
      3'd3:    return !z;
      default: return 1'b0;
    endcase
  endfunction

  // Random values on every decode/flag input outside the phase that uses them.
  task automatic drive_junk();
    is_branch  = 1'($urandom);
    is_jump    = 1'($urandom);
    is_halt    = 1'($urandom);
    writes_reg = 1'($urandom);
    cond       = 3'($urandom);
    target     = 16'($urandom);
    flag_we    = 1'($urandom);
    flag_in    = 4'($urandom);
  endtask

  // Runs one instruction starting at a falling edge in FETCH. Returns at the
  // falling edge after WB (back in FETCH), or in HALT for a halt instruction.
  task automatic run_instr(input bit br, input bit jmp, input bit hlt, input bit wr,
                           input logic [2:0] c, input logic [15:0] tgt,
                           input bit fwe, input logic [3:0] fin, input int dly);
    int  c0;
    bit  exp_taken;
    c0 = cyc;
    for (int k = 0; k < dly; k++) begin
      mem_ready = 1'b0;
      drive_junk();
      #1;
      chk("fetch_wait_state", state, 32'd0);
      chk("fetch_wait_ir_load", ir_load, 32'd0);
      chk("fetch_wait_pc", pc, m_pc);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    drive_junk();
    #1;
    chk("fetch_state", state, 32'd0);
    chk("fetch_ir_load", ir_load, 32'd1);
    chk("fetch_pc", pc, m_pc);
    @(negedge clk);
    mem_ready  = 1'($urandom);
    is_branch  = br;
    is_jump    = jmp;
    is_halt    = hlt;
    writes_reg = wr;
    cond       = c;
    target     = tgt;
    flag_we    = 1'b1;
    flag_in    = 4'($urandom);
    #1;
    chk("decode_state", state, 32'd1);
    chk("decode_ir_load", ir_load, 32'd0);
    @(negedge clk);
    if (hlt) begin
      #1;
      chk("halt_state", state, 32'd4);
      chk("halt_halted", halted, 32'd1);
      chk("halt_pc", pc, m_pc);
      chk("halt_flags", flags, m_flags);
      return;
    end
    drive_junk();
    mem_ready = 1'($urandom);
    flag_we   = fwe;
    flag_in   = fin;
    #1;
    chk("exec_state", state, 32'd2);
    chk("exec_flags", flags, m_flags);
    chk("exec_taken", taken, 32'd0);
    exp_taken = jmp | (br & m_cond_true(c, m_flags[3], m_flags[2], m_flags[0]));
    if (fwe) m_flags = fin;
    @(negedge clk);
    drive_junk();
    flag_we = 1'b1;
    #1;
    chk("wb_state", state, 32'd3);
    chk("wb_reg_we", reg_we, wr);
    chk("wb_taken", taken, exp_taken);
    chk("wb_pc_unchanged", pc, m_pc);
    chk("wb_flags", flags, m_flags);
    m_pc = exp_taken ? tgt : 16'(m_pc + 16'd1);
    @(negedge clk);
    chk("instr_cycles", cyc - c0, 4 + dly);
    chk("next_state", state, 32'd0);
    chk("next_pc", pc, m_pc);
    chk("next_flags", flags, m_flags);
    chk("next_reg_we", reg_we, 32'd0);
    chk("next_taken", taken, 32'd0);
  endtask

  task automatic nop(input int dly);
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'($urandom), 1'b0, 4'd0, dly);
  endtask

  task automatic set_flags(input logic [3:0] f);
    run_instr(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'($urandom), 1'b1, f, 0);
  endtask

  task automatic branch(input logic [2:0] c, input logic [15:0] tgt);
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, c, tgt, 1'b0, 4'd0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pc    = 16'h0000;
    m_flags = 4'h0;
  endtask

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b0;
    drive_junk();
    m_pc      = 16'h0000;
    m_flags   = 4'h0;
    repeat (2) @(negedge clk);
    chk("reset_state", state, 32'd0);
    chk("reset_pc", pc, 32'h0);
    chk("reset_flags", flags, 32'h0);
    chk("reset_ir_load", ir_load, 32'd0);
    chk("reset_reg_we", reg_we, 32'd0);
    chk("reset_taken", taken, 32'd0);
    chk("reset_halted", halted, 32'd0);
    rst = 1'b0;

    // Straight-line NOPs: pc 0,1,2,3.
    repeat (4) nop(0);
    chk("nop_seq_pc", pc, 32'd4);

    // Z set, then EQ taken to 0x0040, then NE not taken.
    set_flags(4'b0100);
    branch(3'b000, 16'h0040);
    chk("beq_target", pc, 32'h0040);
    branch(3'b011, 16'h0080);
    chk("bne_fallthrough", pc, 32'h0041);

    // S=1,V=0: LT and LE taken.
    set_flags(4'b1000);
    branch(3'b001, 16'h0100);
    branch(3'b010, 16'h0200);
    // S=1,V=1,Z=0: LT and LE not taken; reserved code never taken.
    set_flags(4'b1001);
    branch(3'b001, 16'h0300);
    branch(3'b010, 16'h0400);
    branch(3'b101, 16'h0500);

    // Jump overrides a false branch condition.
    set_flags(4'b0100);
    run_instr(1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 16'h0600, 1'b0, 4'd0, 0);
    chk("jump_override_pc", pc, 32'h0600);

    // Jump to all-ones, then a NOP wraps to zero.
    run_instr(1'b0, 1'b1, 1'b0, 1'b1, 3'b111, 16'hFFFF, 1'b0, 4'd0, 0);
    nop(0);
    chk("pc_wrap", pc, 32'h0000);

    // Memory stall of three cycles in FETCH.
    nop(3);

    // Flag update in EXEC must not affect the branch in the same instruction.
    set_flags(4'b0000);
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 16'h0700, 1'b1, 4'b0100, 0);

    // Randomized instruction stream.
    for (int i = 0; i < 150; i++) begin
      run_instr(1'($urandom), ($urandom_range(0, 7) == 0), 1'b0, 1'($urandom),
                3'($urandom), 16'($urandom), 1'($urandom), 4'($urandom),
                int'($urandom_range(0, 2)));
    end

    // Halt: frozen for 20 cycles whatever the inputs do.
    run_instr(1'($urandom), 1'($urandom), 1'b1, 1'($urandom),
              3'($urandom), 16'($urandom), 1'b1, 4'($urandom), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive_junk();
      mem_ready = 1'($urandom);
      #1;
      chk("halt_hold_state", state, 32'd4);
      chk("halt_hold_pc", pc, m_pc);
      chk("halt_hold_flags", flags, m_flags);
      chk("halt_hold_pulses", {ir_load, reg_we, taken, halted}, 32'b0001);
    end
    @(negedge clk);
    do_reset();
    chk("halt_exit_halted", halted, 32'd0);
    chk("halt_exit_pc", pc, 32'h0);

    // Asynchronous reset in the middle of EXEC.
    run_instr(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h1234, 1'b1, 4'b1111, 0);
    chk("pre_reset_pc", pc, 32'h1234);
    mem_ready = 1'b1;
    @(negedge clk);
    is_branch = 1'b0; is_jump = 1'b1; is_halt = 1'b0; writes_reg = 1'b1;
    cond = 3'd0; target = 16'h5555; flag_we = 1'b0;
    @(negedge clk);
    flag_we = 1'b1;
    flag_in = 4'b1010;
    #1;
    chk("pre_reset_exec", state, 32'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("async_reset_pc", pc, 32'h0);
    chk("async_reset_flags", flags, 32'h0);
    chk("async_reset_state", state, 32'd0);
    chk("async_reset_halted", halted, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_pc    = 16'h0000;
    m_flags = 4'h0;
    nop(0);
    chk("post_reset_pc", pc, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pc_sequencer
`default_nettype wire
